// File: rtl/cpu_reg_pkg.sv
// rtl/cpu_reg_pkg.sv - shared op encoding and default width for datapath registers
package cpu_reg_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      OP_HOLD = 3'd0,
      OP_CLR  = 3'd1,
      OP_LD   = 3'd2,
      OP_INR  = 3'd3,
      OP_DCR  = 3'd4,
      OP_SHL  = 3'd5,
      OP_SHR  = 3'd6
   } op_e;

endpackage

// File: rtl/reg_op_sel.sv
// rtl/reg_op_sel.sv - priority encoder from register strobes to a single op
module reg_op_sel
   import cpu_reg_pkg::*;
(
   input  logic clr,
   input  logic ld,
   input  logic inr,
   input  logic dcr,
   input  logic shl,
   input  logic shr,
   output op_e  op
);

   always_comb begin
      op = OP_HOLD;
      if (clr)
         op = OP_CLR;
      else if (ld)
         op = OP_LD;
      else if (inr)
         op = OP_INR;
      else if (dcr)
         op = OP_DCR;
      else if (shl)
         op = OP_SHL;
      else if (shr)
         op = OP_SHR;
   end

endmodule

// File: rtl/cpu_register_x.sv
// rtl/cpu_register_x.sv - general-purpose register/counter with carry, zero and terminal-count flags
module cpu_register_x
   import cpu_reg_pkg::*;
#(
   parameter int                WIDTH     = DATA_W,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0,
   parameter bit                SATURATE  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             ld,
   input  logic             inr,
   input  logic             dcr,
   input  logic             shl,
   input  logic             shr,
   input  logic             sin,
   input  logic [WIDTH-1:0] ld_data,
   output logic [WIDTH-1:0] out,
   output logic             co,
   output logic             tc,
   output logic             zero
);

   op_e op;

   // Declaration initialisers give the reset value at power-up as well.
   logic [WIDTH-1:0] out_q = RESET_VAL;
   logic             co_q  = 1'b0;
   logic             tc_q  = 1'b0;

   logic [WIDTH-1:0] out_d;
   logic             co_d;
   logic             tc_d;

   logic             at_max;
   logic             at_min;

   reg_op_sel u_op_sel (
      .clr (clr),
      .ld  (ld),
      .inr (inr),
      .dcr (dcr),
      .shl (shl),
      .shr (shr),
      .op  (op)
   );

   assign at_max = &out_q;
   assign at_min = ~|out_q;

   always_comb begin
      out_d = out_q;
      co_d  = co_q;
      tc_d  = 1'b0;
      unique case (op)
         OP_CLR: begin
            out_d = '0;
            co_d  = 1'b0;
         end
         OP_LD: begin
            out_d = ld_data;
            co_d  = 1'b0;
         end
         OP_INR: begin
            // In saturate mode the terminal value is held but still flagged.
            if (!(SATURATE && at_max))
               out_d = out_q + 1'b1;
            co_d = at_max;
            tc_d = at_max;
         end
         OP_DCR: begin
            if (!(SATURATE && at_min))
               out_d = out_q - 1'b1;
            co_d = at_min;
            tc_d = at_min;
         end
         OP_SHL: begin
            out_d = {out_q[WIDTH-2:0], sin};
            co_d  = out_q[WIDTH-1];
         end
         OP_SHR: begin
            out_d = {sin, out_q[WIDTH-1:1]};
            co_d  = out_q[0];
         end
         default: begin
            out_d = out_q;
            co_d  = co_q;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= RESET_VAL;
         co_q  <= 1'b0;
         tc_q  <= 1'b0;
      end else begin
         out_q <= out_d;
         co_q  <= co_d;
         tc_q  <= tc_d;
      end
   end

   assign out  = out_q;
   assign co   = co_q;
   assign tc   = tc_q;
   assign zero = ~|out_q;

endmodule

// File: tb/tb_cpu_register_x.sv
// tb/tb_cpu_register_x.sv - directed bench for a wrap-mode and a saturate-mode register
module tb_cpu_register_x;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_w, clr_w, ld_w, inr_w, dcr_w, shl_w, shr_w, sin_w;
   logic [15:0] d_w, out_w;
   logic        co_w, tc_w, zero_w;

   logic        rst_s, clr_s, ld_s, inr_s, dcr_s, shl_s, shr_s, sin_s;
   logic [15:0] d_s, out_s;
   logic        co_s, tc_s, zero_s;

   int n_cmp = 0;
   int n_err = 0;

   cpu_register_x #(.WIDTH(16), .RESET_VAL(16'h0100), .SATURATE(1'b0)) dut_w (
      .clk(clk), .rst(rst_w), .clr(clr_w), .ld(ld_w), .inr(inr_w), .dcr(dcr_w),
      .shl(shl_w), .shr(shr_w), .sin(sin_w), .ld_data(d_w),
      .out(out_w), .co(co_w), .tc(tc_w), .zero(zero_w)
   );

   cpu_register_x #(.WIDTH(16), .RESET_VAL(16'h0000), .SATURATE(1'b1)) dut_s (
      .clk(clk), .rst(rst_s), .clr(clr_s), .ld(ld_s), .inr(inr_s), .dcr(dcr_s),
      .shl(shl_s), .shr(shr_s), .sin(sin_s), .ld_data(d_s),
      .out(out_s), .co(co_s), .tc(tc_s), .zero(zero_s)
   );

   // strobe vector order: {rst, clr, ld, inr, dcr, shl, shr}
   task automatic drv_w(input logic [6:0] s, input logic sin, input logic [15:0] d);
      {rst_w, clr_w, ld_w, inr_w, dcr_w, shl_w, shr_w} = s;
      sin_w = sin;
      d_w   = d;
   endtask

   task automatic drv_s(input logic [6:0] s, input logic sin, input logic [15:0] d);
      {rst_s, clr_s, ld_s, inr_s, dcr_s, shl_s, shr_s} = s;
      sin_s = sin;
      d_s   = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [15:0] o, input logic c, input logic t, input logic z);
      chk({tag, ".out"},  out_w,  o);
      chk({tag, ".co"},   {15'd0, co_w},   {15'd0, c});
      chk({tag, ".tc"},   {15'd0, tc_w},   {15'd0, t});
      chk({tag, ".zero"}, {15'd0, zero_w}, {15'd0, z});
   endtask

   task automatic chk_s(input string tag, input logic [15:0] o, input logic c, input logic t, input logic z);
      chk({tag, ".out"},  out_s,  o);
      chk({tag, ".co"},   {15'd0, co_s},   {15'd0, c});
      chk({tag, ".tc"},   {15'd0, tc_s},   {15'd0, t});
      chk({tag, ".zero"}, {15'd0, zero_s}, {15'd0, z});
   endtask

   initial begin
      drv_w(7'b1000000, 1'b0, 16'h0000);
      drv_s(7'b1000000, 1'b0, 16'h0000);
      tick();
      chk_w("w_reset", 16'h0100, 1'b0, 1'b0, 1'b0);
      chk_s("s_reset", 16'h0000, 1'b0, 1'b0, 1'b1);
      drv_s(7'b0000000, 1'b0, 16'h0000);

      drv_w(7'b0010000, 1'b0, 16'hFFFE); tick();
      chk_w("w_ld_fffe", 16'hFFFE, 1'b0, 1'b0, 1'b0);
      drv_w(7'b0001000, 1'b0, 16'h0000); tick();
      chk_w("w_inr_ffff", 16'hFFFF, 1'b0, 1'b0, 1'b0);
      tick();
      chk_w("w_inr_wrap", 16'h0000, 1'b1, 1'b1, 1'b1);
      drv_w(7'b0000000, 1'b0, 16'h0000); tick();
      chk_w("w_hold", 16'h0000, 1'b1, 1'b0, 1'b1);

      drv_w(7'b0000100, 1'b0, 16'h0000); tick();
      chk_w("w_dcr_wrap", 16'hFFFF, 1'b1, 1'b1, 1'b0);
      drv_w(7'b0000100, 1'b0, 16'h0000); tick();
      chk_w("w_dcr_plain", 16'hFFFE, 1'b0, 1'b0, 1'b0);

      drv_w(7'b0010000, 1'b0, 16'h8001); tick();
      chk_w("w_ld_8001", 16'h8001, 1'b0, 1'b0, 1'b0);
      drv_w(7'b0000010, 1'b0, 16'h0000); tick();
      chk_w("w_shl", 16'h0002, 1'b1, 1'b0, 1'b0);
      drv_w(7'b0000001, 1'b1, 16'h0000); tick();
      chk_w("w_shr", 16'h8001, 1'b0, 1'b0, 1'b0);
      drv_w(7'b0000001, 1'b0, 16'h0000); tick();
      chk_w("w_shr_co", 16'h4000, 1'b1, 1'b0, 1'b0);

      drv_w(7'b0111000, 1'b0, 16'h1234); tick();
      chk_w("w_clr_ld_inr", 16'h0000, 1'b0, 1'b0, 1'b1);
      drv_w(7'b0011000, 1'b0, 16'h0005); tick();
      chk_w("w_ld_inr", 16'h0005, 1'b0, 1'b0, 1'b0);
      drv_w(7'b0010000, 1'b0, 16'h0010); tick();
      drv_w(7'b0001100, 1'b0, 16'h0000); tick();
      chk_w("w_inr_dcr", 16'h0011, 1'b0, 1'b0, 1'b0);
      drv_w(7'b0010000, 1'b0, 16'h0010); tick();
      drv_w(7'b0000110, 1'b1, 16'h0000); tick();
      chk_w("w_dcr_shl", 16'h000F, 1'b0, 1'b0, 1'b0);

      drv_w(7'b1010000, 1'b0, 16'h1234); tick();
      chk_w("w_rst_ld", 16'h0100, 1'b0, 1'b0, 1'b0);
      drv_w(7'b0001000, 1'b0, 16'h0000); tick();
      chk_w("w_resume", 16'h0101, 1'b0, 1'b0, 1'b0);
      drv_w(7'b0000000, 1'b0, 16'h0000);

      drv_s(7'b0000100, 1'b0, 16'h0000); tick();
      chk_s("s_dcr0", 16'h0000, 1'b1, 1'b1, 1'b1);
      tick();
      chk_s("s_dcr1", 16'h0000, 1'b1, 1'b1, 1'b1);
      tick();
      chk_s("s_dcr2", 16'h0000, 1'b1, 1'b1, 1'b1);
      drv_s(7'b0001000, 1'b0, 16'h0000); tick();
      chk_s("s_inr", 16'h0001, 1'b0, 1'b0, 1'b0);
      drv_s(7'b0010000, 1'b0, 16'hFFFF); tick();
      chk_s("s_ld_ffff", 16'hFFFF, 1'b0, 1'b0, 1'b0);
      drv_s(7'b0001000, 1'b0, 16'h0000); tick();
      chk_s("s_inr_sat0", 16'hFFFF, 1'b1, 1'b1, 1'b0);
      tick();
      chk_s("s_inr_sat1", 16'hFFFF, 1'b1, 1'b1, 1'b0);
      drv_s(7'b0000100, 1'b0, 16'h0000); tick();
      chk_s("s_dcr_top", 16'hFFFE, 1'b0, 1'b0, 1'b0);
      drv_s(7'b0000000, 1'b0, 16'h0000); tick();
      chk_s("s_hold", 16'hFFFE, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
